// File: rtl/if_stage_pkg.sv
// Core-wide constants shared by the fetch stage and its neighbours:
// datapath width, the canonical bubble instruction, reset PC and fetch state encoding.
package if_stage_pkg;

   localparam int XLEN = 32;

   // addi x0,x0,0
   localparam logic [XLEN-1:0] NOP_INST_ENC = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      FS_BUBBLE = 2'd0,
      FS_RUN    = 2'd1,
      FS_HOLD   = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives a synchronous-read ROM and presents
// the aligned {inst, pc, pc4, have_inst} bundle to decode, handling stalls and redirects.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
   parameter logic [XLEN-1:0] NOP_INST = NOP_INST_ENC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] irom_addr,
   input  logic [XLEN-1:0] irom_inst,
   output logic [XLEN-1:0] id_inst,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc4,
   output logic            id_have_inst,
   output logic [XLEN-1:0] fetch_count
);

   fetch_state_e    state, state_d;
   logic [XLEN-1:0] pc_f, pc_f_d;
   logic [XLEN-1:0] id_pc_d, id_pc4_d;
   logic [XLEN-1:0] hold_inst, hold_inst_d;
   logic [XLEN-1:0] fetch_count_d;
   logic [XLEN-1:0] pc_f_plus4;
   logic            unused_rpc_bits;

   assign pc_f_plus4      = pc_f + 32'd4;
   assign unused_rpc_bits = ^redirect_pc[1:0];

   // Next-state: redirect beats stall, stall beats advance
   always_comb begin
      state_d       = state;
      pc_f_d        = pc_f;
      id_pc_d       = id_pc;
      id_pc4_d      = id_pc4;
      hold_inst_d   = hold_inst;
      fetch_count_d = fetch_count;
      if (redirect) begin
         pc_f_d  = {redirect_pc[XLEN-1:2], 2'b00};
         state_d = FS_BUBBLE;
      end else if (stall) begin
         // Capture the ROM word once; the ROM keeps seeing pc_f while stalled
         if (state == FS_RUN) begin
            hold_inst_d = irom_inst;
            state_d     = FS_HOLD;
         end
      end else begin
         pc_f_d   = pc_f_plus4;
         id_pc_d  = pc_f;
         id_pc4_d = pc_f_plus4;
         state_d  = FS_RUN;
         if (state != FS_BUBBLE) begin
            fetch_count_d = fetch_count + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FS_BUBBLE;
         pc_f        <= RESET_PC;
         id_pc       <= '0;
         id_pc4      <= '0;
         hold_inst   <= '0;
         fetch_count <= '0;
      end else begin
         state       <= state_d;
         pc_f        <= pc_f_d;
         id_pc       <= id_pc_d;
         id_pc4      <= id_pc4_d;
         hold_inst   <= hold_inst_d;
         fetch_count <= fetch_count_d;
      end
   end

   // Decode bundle selection
   always_comb begin
      id_inst      = NOP_INST;
      id_have_inst = 1'b0;
      case (state)
         FS_RUN: begin
            id_inst      = irom_inst;
            id_have_inst = 1'b1;
         end
         FS_HOLD: begin
            id_inst      = hold_inst;
            id_have_inst = 1'b1;
         end
         default: begin
            id_inst      = NOP_INST;
            id_have_inst = 1'b0;
         end
      endcase
   end

   assign irom_addr = pc_f;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed per-cycle vectors push hand-computed bundles,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] irom_addr;
   logic [31:0] irom_inst = 32'h0;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;
   logic        id_have_inst;
   logic [31:0] fetch_count;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        have;
      logic [31:0] cnt;
      logic [31:0] addr;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc_no  = 0;

   if_stage dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .irom_addr    (irom_addr),
      .irom_inst    (irom_inst),
      .id_inst      (id_inst),
      .id_pc        (id_pc),
      .id_pc4       (id_pc4),
      .id_have_inst (id_have_inst),
      .fetch_count  (fetch_count)
   );

   always #5 clk = ~clk;

   // Synchronous-read ROM: word at byte address a is 0x1000_0000 + a
   always @(posedge clk) irom_inst <= 32'h1000_0000 + irom_addr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL cycle %0d %s: got 0x%08h expected 0x%08h", cyc_no, name, act, expv);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("id_inst",      id_inst,               e.inst);
            check("id_pc",        id_pc,                 e.pc);
            check("id_pc4",       id_pc4,                e.pc4);
            check("id_have_inst", {31'b0, id_have_inst}, {31'b0, e.have});
            check("fetch_count",  fetch_count,           e.cnt);
            check("irom_addr",    irom_addr,             e.addr);
         end
      end
   end

   // Apply inputs for one cycle and queue the outputs expected during that cycle
   task automatic cyc(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                      input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] pc4,
                      input logic have, input logic [31:0] cnt, input logic [31:0] addr);
      exp_t e;
      rst         = r;
      stall       = s;
      redirect    = rd;
      redirect_pc = rpc;
      e.inst = inst; e.pc = pc; e.pc4 = pc4; e.have = have; e.cnt = cnt; e.addr = addr;
      q.push_back(e);
      @(posedge clk);
      #1;
      cyc_no++;
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      @(posedge clk);
      #1;
      //   rst stl rd  rpc           inst          pc            pc4           hv cnt    addr
      cyc(1, 0, 0, 32'h0,         32'h0000_0013, 32'h0,        32'h0,        0, 32'd0, 32'h0);
      // reset release: bubble, then ROM[0], ROM[4]
      cyc(0, 0, 0, 32'h0,         32'h0000_0013, 32'h0,        32'h0,        0, 32'd0, 32'h0);
      cyc(0, 0, 0, 32'h0,         32'h1000_0000, 32'h0,        32'h4,        1, 32'd0, 32'h4);
      cyc(0, 0, 0, 32'h0,         32'h1000_0004, 32'h4,        32'h8,        1, 32'd1, 32'h8);
      // stall 3 cycles at id_pc=8: bundle stable for 4 cycles
      cyc(0, 1, 0, 32'h0,         32'h1000_0008, 32'h8,        32'hC,        1, 32'd2, 32'hC);
      cyc(0, 1, 0, 32'h0,         32'h1000_0008, 32'h8,        32'hC,        1, 32'd2, 32'hC);
      cyc(0, 1, 0, 32'h0,         32'h1000_0008, 32'h8,        32'hC,        1, 32'd2, 32'hC);
      cyc(0, 0, 0, 32'h0,         32'h1000_0008, 32'h8,        32'hC,        1, 32'd2, 32'hC);
      cyc(0, 0, 0, 32'h0,         32'h1000_000C, 32'hC,        32'h10,       1, 32'd3, 32'h10);
      // redirect to 0x40 while id_pc=0x10
      cyc(0, 0, 1, 32'h40,        32'h1000_0010, 32'h10,       32'h14,       1, 32'd4, 32'h14);
      cyc(0, 0, 0, 32'h0,         32'h0000_0013, 32'h10,       32'h14,       0, 32'd4, 32'h40);
      cyc(0, 0, 0, 32'h0,         32'h1000_0040, 32'h40,       32'h44,       1, 32'd4, 32'h44);
      // redirect + stall together to 0x83, stall held through the bubble
      cyc(0, 1, 1, 32'h83,        32'h1000_0044, 32'h44,       32'h48,       1, 32'd5, 32'h48);
      cyc(0, 1, 0, 32'h0,         32'h0000_0013, 32'h44,       32'h48,       0, 32'd5, 32'h80);
      cyc(0, 1, 0, 32'h0,         32'h0000_0013, 32'h44,       32'h48,       0, 32'd5, 32'h80);
      cyc(0, 0, 0, 32'h0,         32'h0000_0013, 32'h44,       32'h48,       0, 32'd5, 32'h80);
      cyc(0, 0, 0, 32'h0,         32'h1000_0080, 32'h80,       32'h84,       1, 32'd5, 32'h84);
      // enter HOLD, then reset in the middle of it
      cyc(0, 1, 0, 32'h0,         32'h1000_0084, 32'h84,       32'h88,       1, 32'd6, 32'h88);
      cyc(1, 1, 0, 32'h0,         32'h1000_0084, 32'h84,       32'h88,       1, 32'd6, 32'h88);
      cyc(0, 0, 0, 32'h0,         32'h0000_0013, 32'h0,        32'h0,        0, 32'd0, 32'h0);
      // redirect to the top of the address space, low bits masked; PC wraps to 0
      cyc(0, 0, 1, 32'hFFFF_FFFF, 32'h1000_0000, 32'h0,        32'h4,        1, 32'd0, 32'h4);
      cyc(0, 0, 0, 32'h0,         32'h0000_0013, 32'h0,        32'h4,        0, 32'd0, 32'hFFFF_FFFC);
      cyc(0, 0, 0, 32'h0,         32'h0FFF_FFFC, 32'hFFFF_FFFC, 32'h0,       1, 32'd0, 32'h0);
      cyc(0, 0, 0, 32'h0,         32'h1000_0000, 32'h0,        32'h4,        1, 32'd1, 32'h4);
      @(negedge clk);
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined RISC-V core. It owns the PC, drives a synchronous-read instruction ROM, and presents an aligned {inst, pc, pc4, have_inst} bundle to the decode stage, which in turn feeds the ID/EX pipeline register. It handles the load-use stall from the hazard logic, branch/jump redirects from EX, and holds the in-flight ROM word during stalls so that no instruction is lost or duplicated.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- NOP_INST, 32'h0000_0013, instruction driven while the stage holds a bubble (addi x0,x0,0)

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- stall  in  1  hazard unit load-use stall; hold PC and decode bundle
- redirect  in  1  branch taken or jump resolved in EX
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and treated as 00
- irom_addr  out  32  byte address to instruction ROM; equals pc_f (register output)
- irom_inst  in  32  ROM read data; valid the cycle after irom_addr is presented
- id_inst  out  32  instruction for decode
- id_pc  out  32  PC of id_inst
- id_pc4  out  32  id_pc + 4
- id_have_inst  out  1  id bundle holds a real instruction
- fetch_count  out  32  number of instructions delivered to decode (debug)

## Operation
- Registers: pc_f (fetch PC), id_pc, id_pc4, hold_inst, state, fetch_count.
- States: BUBBLE, RUN, HOLD. id_inst = NOP_INST in BUBBLE, irom_inst in RUN, hold_inst in HOLD. id_have_inst = 0 in BUBBLE, 1 otherwise (combinational from state).
- Priority each cycle: rst > redirect > stall > advance.
- Advance (no redirect, no stall): pc_f <= pc_f+4; id_pc <= pc_f; id_pc4 <= pc_f+4; state <= RUN.
- Stall (no redirect): pc_f, id_pc, id_pc4 hold. RUN -> HOLD, capturing hold_inst <= irom_inst. HOLD stays HOLD (hold_inst unchanged). BUBBLE stays BUBBLE.
- Stall release in HOLD: normal advance; ROM has been presented pc_f throughout the stall, so irom_inst is correct on the following cycle.
- Redirect (with or without stall): pc_f <= {redirect_pc[31:2],2'b00}; id_pc, id_pc4 hold; state <= BUBBLE. The next cycle is a bubble because irom_inst still corresponds to the squashed address.
- fetch_count increments by 1 at each clock edge where state is RUN or HOLD and the cycle is an advance (not stall, not redirect); wraps 0xFFFF_FFFF -> 0.
- PC arithmetic is modulo 2^32; pc_f = 0xFFFF_FFFC advances to 0x0000_0000.

## Timing
- Reset (sync): pc_f = RESET_PC, id_pc = 0, id_pc4 = 0, hold_inst = 0, fetch_count = 0, state = BUBBLE -> id_inst = NOP_INST, id_have_inst = 0, irom_addr = RESET_PC.
- First cycle after rst deasserts: irom_addr = RESET_PC, bubble. Second cycle: id_pc = RESET_PC, id_inst = ROM[RESET_PC], id_have_inst = 1.
- Fetch-to-decode latency: 1 cycle (address at N, bundle at N+1).
- Redirect asserted in cycle N: bubble in N+1; target instruction on id_* in N+2 (redirect penalty = 2 bundles including the squashed one the ID/EX flush removes).
- Stall for k cycles: the id bundle is stable and identical for k+1 cycles; no skipped or repeated PC afterwards.
- rst during HOLD or BUBBLE: returns to reset values at the next edge; hold_inst content is discarded.

## Structure
- Shared package (core-wide): XLEN = 32, NOP_INST encoding, RESET_PC default, fetch state encoding (BUBBLE/RUN/HOLD).
- Single module; no sub-module. PC register and the IF/ID bundle live together because the hold buffer and bubble masking depend on both.

## Test plan
- Reset release, ROM[i]=0x1000_0000+i: cycle 1 bubble (id_inst=0x13, have_inst=0), cycle 2 id_pc=0/id_inst=0x1000_0000, cycle 3 id_pc=4/0x1000_0004; fetch_count=2 after cycle 3.
- Stall 3 cycles while id_pc=8: id_pc=8, id_inst=ROM[8] for 4 cycles, then id_pc=0xC with ROM[0xC]; no duplicate PC.
- Redirect to 0x40 when id_pc=0x10: next cycle have_inst=0, id_inst=0x13; following cycle id_pc=0x40, id_pc4=0x44, id_inst=ROM[0x40].
- Redirect and stall in same cycle, redirect_pc=0x83: redirect wins, pc_f=0x80, bubble, then id_pc=0x80 after stall drops.
- Stall held across redirect then stall during BUBBLE: stays bubble, fetch_count unchanged until first advance.
- rst asserted mid-HOLD: next cycle all outputs equal reset values; irom_addr=RESET_PC.
